// File: rtl/hack_computer.sv
// Hack computer: CPU, 32K-word instruction ROM and memory-mapped data memory.
// Define HACK_SCREEN_EN to map an 8K-word screen RAM at 0x4000-0x5FFF.

module hack_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          load,
    input  logic [AW-1:0] address,
    input  logic [15:0]   data_in,
    output logic [15:0]   data_out
);
    logic [15:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (load)
            mem[address] <= data_in;
    end

    assign data_out = mem[address];
endmodule

module hack_rom32k (
    input  logic [14:0] address,
    output logic [15:0] data_out
);
    logic [15:0] mem [0:32767];

    assign data_out = mem[address];
endmodule

module hack_memory (
    input  logic        clk,
    input  logic        load,
    input  logic [14:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out
);
    logic        ram_sel;
    logic [15:0] ram_out;

    assign ram_sel = ~address[14];

    hack_ram #(.AW(14)) RAM16K (
        .clk(clk), .load(load & ram_sel), .address(address[13:0]),
        .data_in(data_in), .data_out(ram_out)
    );

`ifdef HACK_SCREEN_EN
    logic        scr_sel;
    logic [15:0] scr_out;

    assign scr_sel = (address[14:13] == 2'b10);

    hack_ram #(.AW(13)) SCREEN (
        .clk(clk), .load(load & scr_sel), .address(address[12:0]),
        .data_in(data_in), .data_out(scr_out)
    );

    assign data_out = ram_sel ? ram_out : (scr_sel ? scr_out : 16'd0);
`else
    // Screen window, keyboard and everything above read as zero.
    assign data_out = ram_sel ? ram_out : 16'd0;
`endif
endmodule

module hack_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic [15:0] inM,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [14:0] pc
);
    logic [15:0] A_reg, D_reg;
    logic [15:0] x_val, y_val, alu_out;
    logic        is_c, zr, ng, jump;
    logic        unused_bits;

    assign is_c        = instruction[15];
    assign unused_bits = ^instruction[14:13];

    always_comb begin
        x_val = instruction[11] ? 16'd0 : D_reg;
        x_val = instruction[10] ? ~x_val : x_val;
        y_val = instruction[9] ? 16'd0 : (instruction[12] ? inM : A_reg);
        y_val = instruction[8] ? ~y_val : y_val;
        alu_out = instruction[7] ? (x_val + y_val) : (x_val & y_val);
        alu_out = instruction[6] ? ~alu_out : alu_out;
    end

    assign zr   = (alu_out == 16'd0);
    assign ng   = alu_out[15];
    assign jump = is_c & ((instruction[2] & ng) | (instruction[1] & zr) |
                          (instruction[0] & ~ng & ~zr));

    assign outM     = alu_out;
    assign addressM = A_reg[14:0];
    assign writeM   = is_c & instruction[3] & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A_reg <= 16'd0;
            D_reg <= 16'd0;
            pc    <= 15'd0;
        end else begin
            if (!is_c)
                A_reg <= instruction;
            else if (instruction[5])
                A_reg <= alu_out;
            if (is_c && instruction[4])
                D_reg <= alu_out;
            // Jump target and write address both use the pre-edge A_reg.
            pc <= jump ? A_reg[14:0] : pc + 15'd1;
        end
    end
endmodule

module hack_computer (
    input logic clk,
    input logic reset
);
    logic [14:0] pc, addressM;
    logic [15:0] instruction, inM, outM;
    logic        writeM;

    hack_rom32k ROM32K (
        .address(pc), .data_out(instruction)
    );

    hack_cpu CPU (
        .clk(clk), .reset(reset), .instruction(instruction), .inM(inM),
        .outM(outM), .writeM(writeM), .addressM(addressM), .pc(pc)
    );

    hack_memory Memory (
        .clk(clk), .load(writeM), .address(addressM),
        .data_in(outM), .data_out(inM)
    );
endmodule

// File: tb/tb_hack_computer.sv
// Directed-vector bench for hack_computer: hand-assembled programs poked into ROM,
// register/RAM state checked against hand-computed values.

module tb_hack_computer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [15:0] prog [0:15];

    localparam logic [15:0] D_EQ_A    = 16'hEC10;
    localparam logic [15:0] D_DPLUSA  = 16'hE090;
    localparam logic [15:0] M_EQ_D    = 16'hE308;
    localparam logic [15:0] JMP0      = 16'hEA87;
    localparam logic [15:0] D_ZERO    = 16'hEA90;
    localparam logic [15:0] D_JGT     = 16'hE301;
    localparam logic [15:0] D_JEQ     = 16'hE302;
    localparam logic [15:0] D_DANDA   = 16'hE010;
    localparam logic [15:0] D_NOTD    = 16'hE350;
    localparam logic [15:0] D_MINUS1  = 16'hEE90;
    localparam logic [15:0] A_MINUS1  = 16'hEEA0;
    localparam logic [15:0] D_DPLUS1  = 16'hE7D0;
    localparam logic [15:0] AM_DPLUS1 = 16'hE7E8;
    localparam logic [15:0] M_MINUS1  = 16'hEE88;
    localparam logic [15:0] D_EQ_M    = 16'hFC10;

`ifdef HACK_SCREEN_EN
    localparam logic [15:0] SCR_EXP = 16'hFFFF;
`else
    localparam logic [15:0] SCR_EXP = 16'h0000;
`endif

    always #5 clk = ~clk;

    hack_computer dut (.clk(clk), .reset(reset));

    task load_rom(input int n);
        reset = 1'b1;
        for (int i = 0; i < 32768; i++) dut.ROM32K.mem[i] = 16'd0;
        for (int i = 0; i < n; i++) dut.ROM32K.mem[i] = prog[i];
    endtask

    task release_reset;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task test_reset;
        prog[0] = 16'd7; prog[1] = D_EQ_A;
        load_rom(2);
        release_reset();
        step(2);
        vectors++; if (dut.CPU.A_reg !== 16'd7) begin miscompares++; $display("FAIL reset_pre_a got %0d want 7", dut.CPU.A_reg); end
        vectors++; if (dut.CPU.D_reg !== 16'd7) begin miscompares++; $display("FAIL reset_pre_d got %0d want 7", dut.CPU.D_reg); end
        vectors++; if (dut.CPU.pc !== 15'd2) begin miscompares++; $display("FAIL reset_pre_pc got %0d want 2", dut.CPU.pc); end
        vectors++; if (dut.Memory.RAM16K.mem[0] !== 16'd0) begin miscompares++; $display("FAIL reset_ram0 got %0d want 0", dut.Memory.RAM16K.mem[0]); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (dut.CPU.A_reg !== 16'd0) begin miscompares++; $display("FAIL reset_async_a got %0d want 0", dut.CPU.A_reg); end
        vectors++; if (dut.CPU.D_reg !== 16'd0) begin miscompares++; $display("FAIL reset_async_d got %0d want 0", dut.CPU.D_reg); end
        vectors++; if (dut.CPU.pc !== 15'd0) begin miscompares++; $display("FAIL reset_async_pc got %0d want 0", dut.CPU.pc); end
        step(1);
        vectors++; if (dut.CPU.pc !== 15'd0 || dut.CPU.A_reg !== 16'd0) begin miscompares++; $display("FAIL reset_hold pc=%0d a=%0d want 0 0", dut.CPU.pc, dut.CPU.A_reg); end
        $display("test_reset done");
    endtask

    task test_add;
        prog[0] = 16'd2; prog[1] = D_EQ_A; prog[2] = 16'd3;
        prog[3] = D_DPLUSA; prog[4] = 16'd0; prog[5] = M_EQ_D;
        load_rom(6);
        release_reset();
        step(6);
        vectors++; if (dut.Memory.RAM16K.mem[0] !== 16'd5) begin miscompares++; $display("FAIL add_ram0 got %0d want 5", dut.Memory.RAM16K.mem[0]); end
        vectors++; if (dut.CPU.D_reg !== 16'd5) begin miscompares++; $display("FAIL add_d got %0d want 5", dut.CPU.D_reg); end
        vectors++; if (dut.CPU.A_reg !== 16'd0) begin miscompares++; $display("FAIL add_a got %0d want 0", dut.CPU.A_reg); end
        vectors++; if (dut.CPU.pc !== 15'd6) begin miscompares++; $display("FAIL add_pc got %0d want 6", dut.CPU.pc); end
        $display("test_add done");
    endtask

    task test_reset_midrun;
        prog[0] = 16'd2; prog[1] = D_EQ_A; prog[2] = 16'd3;
        prog[3] = D_DPLUSA; prog[4] = 16'd0; prog[5] = M_EQ_D;
        load_rom(6);
        dut.Memory.RAM16K.mem[0] = 16'd0;
        release_reset();
        step(6);
        vectors++; if (dut.Memory.RAM16K.mem[0] !== 16'd5) begin miscompares++; $display("FAIL midrun_ram0_pre got %0d want 5", dut.Memory.RAM16K.mem[0]); end
        // While reset holds pc at 0, ROM[0] becomes a write that must stay gated.
        dut.ROM32K.mem[0] = M_EQ_D;
        #1 reset = 1'b1;
        #1;
        vectors++; if (dut.CPU.pc !== 15'd0) begin miscompares++; $display("FAIL midrun_pc got %0d want 0", dut.CPU.pc); end
        vectors++; if (dut.CPU.writeM !== 1'b0) begin miscompares++; $display("FAIL midrun_writem got %0b want 0", dut.CPU.writeM); end
        #26;
        vectors++; if (dut.CPU.pc !== 15'd0) begin miscompares++; $display("FAIL midrun_pc_hold got %0d want 0", dut.CPU.pc); end
        vectors++; if (dut.Memory.RAM16K.mem[0] !== 16'd5) begin miscompares++; $display("FAIL midrun_ram0_kept got %0d want 5", dut.Memory.RAM16K.mem[0]); end
        reset = 1'b0;
        $display("test_reset_midrun done");
    endtask

    task test_alu;
        prog[0] = 16'd5; prog[1] = D_EQ_A; prog[2] = A_MINUS1; prog[3] = D_DANDA;
        prog[4] = D_NOTD; prog[5] = D_MINUS1; prog[6] = D_DPLUS1;
        load_rom(7);
        release_reset();
        step(3);
        vectors++; if (dut.CPU.A_reg !== 16'hFFFF) begin miscompares++; $display("FAIL alu_a_minus1 got %0d want 65535", dut.CPU.A_reg); end
        step(1);
        vectors++; if (dut.CPU.D_reg !== 16'd5) begin miscompares++; $display("FAIL alu_and got %0d want 5", dut.CPU.D_reg); end
        vectors++; if (dut.CPU.ng !== 1'b1) begin miscompares++; $display("FAIL alu_ng got %0b want 1", dut.CPU.ng); end
        step(1);
        vectors++; if (dut.CPU.D_reg !== 16'd65530) begin miscompares++; $display("FAIL alu_not got %0d want 65530", dut.CPU.D_reg); end
        step(1);
        vectors++; if (dut.CPU.zr !== 1'b1) begin miscompares++; $display("FAIL alu_zr got %0b want 1", dut.CPU.zr); end
        vectors++; if (dut.CPU.outM !== 16'd0) begin miscompares++; $display("FAIL alu_outm got %0d want 0", dut.CPU.outM); end
        step(1);
        vectors++; if (dut.CPU.D_reg !== 16'd0) begin miscompares++; $display("FAIL alu_inc got %0d want 0", dut.CPU.D_reg); end
        $display("test_alu done");
    endtask

    task test_jump;
        for (int i = 0; i < 16; i++) prog[i] = 16'd0;
        prog[0] = 16'd10; prog[1] = JMP0;
        prog[10] = D_ZERO; prog[11] = 16'd20; prog[12] = D_JGT; prog[13] = D_JEQ;
        load_rom(14);
        release_reset();
        step(2);
        vectors++; if (dut.CPU.pc !== 15'd10) begin miscompares++; $display("FAIL jump_jmp got %0d want 10", dut.CPU.pc); end
        step(3);
        vectors++; if (dut.CPU.pc !== 15'd13) begin miscompares++; $display("FAIL jump_jgt got %0d want 13", dut.CPU.pc); end
        step(1);
        vectors++; if (dut.CPU.pc !== 15'd20) begin miscompares++; $display("FAIL jump_jeq got %0d want 20", dut.CPU.pc); end
        $display("test_jump done");
    endtask

    task test_back_to_back;
        prog[0] = 16'd7; prog[1] = D_EQ_A; prog[2] = 16'd100;
        prog[3] = AM_DPLUS1; prog[4] = M_EQ_D;
        load_rom(5);
        dut.Memory.RAM16K.mem[8] = 16'd0;
        dut.Memory.RAM16K.mem[100] = 16'd0;
        release_reset();
        step(4);
        vectors++; if (dut.Memory.RAM16K.mem[100] !== 16'd8) begin miscompares++; $display("FAIL b2b_ram100 got %0d want 8", dut.Memory.RAM16K.mem[100]); end
        vectors++; if (dut.CPU.A_reg !== 16'd8) begin miscompares++; $display("FAIL b2b_a got %0d want 8", dut.CPU.A_reg); end
        vectors++; if (dut.Memory.RAM16K.mem[8] !== 16'd0) begin miscompares++; $display("FAIL b2b_ram8_pre got %0d want 0", dut.Memory.RAM16K.mem[8]); end
        step(1);
        vectors++; if (dut.Memory.RAM16K.mem[8] !== 16'd7) begin miscompares++; $display("FAIL b2b_ram8 got %0d want 7", dut.Memory.RAM16K.mem[8]); end
        $display("test_back_to_back done");
    endtask

    task test_pc_wrap;
        prog[0] = 16'h7FFF; prog[1] = JMP0;
        load_rom(2);
        dut.ROM32K.mem[32767] = 16'd3;
        release_reset();
        step(2);
        vectors++; if (dut.CPU.pc !== 15'd32767) begin miscompares++; $display("FAIL wrap_top got %0d want 32767", dut.CPU.pc); end
        step(1);
        vectors++; if (dut.CPU.pc !== 15'd0) begin miscompares++; $display("FAIL wrap_zero got %0d want 0", dut.CPU.pc); end
        vectors++; if (dut.CPU.A_reg !== 16'd3) begin miscompares++; $display("FAIL wrap_a got %0d want 3", dut.CPU.A_reg); end
        $display("test_pc_wrap done");
    endtask

    task test_screen;
        prog[0] = 16'd16384; prog[1] = M_MINUS1; prog[2] = D_EQ_M;
        prog[3] = 16'd24576; prog[4] = M_MINUS1; prog[5] = D_EQ_M;
        load_rom(6);
        dut.Memory.RAM16K.mem[0] = 16'd0;
        dut.Memory.RAM16K.mem[8192] = 16'd0;
        release_reset();
        step(3);
        vectors++; if (dut.CPU.D_reg !== SCR_EXP) begin miscompares++; $display("FAIL screen_d got %0d want %0d", dut.CPU.D_reg, SCR_EXP); end
        step(3);
        vectors++; if (dut.CPU.D_reg !== 16'd0) begin miscompares++; $display("FAIL kbd_d got %0d want 0", dut.CPU.D_reg); end
        vectors++; if (dut.Memory.RAM16K.mem[0] !== 16'd0) begin miscompares++; $display("FAIL screen_alias_ram0 got %0d want 0", dut.Memory.RAM16K.mem[0]); end
        vectors++; if (dut.Memory.RAM16K.mem[8192] !== 16'd0) begin miscompares++; $display("FAIL kbd_alias_ram8192 got %0d want 0", dut.Memory.RAM16K.mem[8192]); end
        $display("test_screen done");
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) dut.Memory.RAM16K.mem[i] = 16'd0;
`ifdef HACK_SCREEN_EN
        for (int i = 0; i < 8192; i++) dut.Memory.SCREEN.mem[i] = 16'd0;
`endif
        test_reset();
        test_add();
        test_reset_midrun();
        test_alu();
        test_jump();
        test_back_to_back();
        test_pc_wrap();
        test_screen();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
